// File: rtl/memory_stage_if.sv
// Data-bus handshake between the memory stage (master) and the data memory (slave).
// Requests stay stable until addr_ok; data_ok marks completion and valid read data.
interface memory_stage_if;
   logic        dreq_valid;
   logic [63:0] dreq_addr;
   logic [1:0]  dreq_size;
   logic [7:0]  dreq_strobe;
   logic [63:0] dreq_data;
   logic        dresp_addr_ok;
   logic        dresp_data_ok;
   logic [63:0] dresp_data;

   modport master (
      output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
      input  dresp_addr_ok, dresp_data_ok, dresp_data
   );

   modport slave (
      input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
      output dresp_addr_ok, dresp_data_ok, dresp_data
   );
endinterface

// File: rtl/memory_stage.sv
// Memory pipeline stage: issues one data-bus access per load/store, formats load data,
// and hands a registered result to writeback. Non-memory ops pass through in one cycle.
module memory_stage #(
   parameter bit CHECK_ALIGN = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [63:0]          in_pc,
   input  logic [63:0]          in_alu,
   input  logic [63:0]          in_rs2,
   input  logic                 in_mem_read,
   input  logic                 in_mem_write,
   input  logic [1:0]           in_size,
   input  logic                 in_unsigned,
   memory_stage_if.master       dbus,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [63:0]          out_pc,
   output logic [63:0]          out_result,
   output logic                 out_misalign
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t      state_q, state_d;
   logic        dreq_valid_q, dreq_valid_d;
   logic [63:0] dreq_addr_q, dreq_addr_d;
   logic [1:0]  dreq_size_q, dreq_size_d;
   logic [7:0]  dreq_strobe_q, dreq_strobe_d;
   logic [63:0] dreq_data_q, dreq_data_d;
   logic [63:0] pc_q, pc_d;
   logic        uns_q, uns_d;
   logic        load_q, load_d;
   logic        out_valid_q, out_valid_d;
   logic [63:0] out_pc_q, out_pc_d;
   logic [63:0] out_result_q, out_result_d;
   logic        out_misalign_q, out_misalign_d;

   logic        accept;
   logic        is_mem_in;
   logic        misalign_in;
   logic        suppress_in;
   logic [7:0]  size_mask;
   logic [7:0]  strobe_in;
   logic [63:0] data_in;
   logic [63:0] raw;
   logic [63:0] load_val;
   logic        finish;

   assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
   assign accept    = in_valid && in_ready;
   assign is_mem_in = in_mem_read || in_mem_write;

   always_comb begin
      misalign_in = 1'b0;
      size_mask   = 8'hFF;
      case (in_size)
         2'd0: size_mask = 8'h01;
         2'd1: begin size_mask = 8'h03; misalign_in = in_alu[0];     end
         2'd2: begin size_mask = 8'h0F; misalign_in = |in_alu[1:0];  end
         default: begin size_mask = 8'hFF; misalign_in = |in_alu[2:0]; end
      endcase
   end

   // With the check disabled the strobe simply loses lanes shifted past byte 7.
   assign suppress_in = CHECK_ALIGN && is_mem_in && misalign_in;
   assign strobe_in   = size_mask << in_alu[2:0];
   assign data_in     = in_rs2 << {in_alu[2:0], 3'b000};

   // Read data arrives unshifted; move the addressed lane down to bit 0.
   assign raw = dbus.dresp_data >> {dreq_addr_q[2:0], 3'b000};

   always_comb begin
      load_val = raw;
      case (dreq_size_q)
         2'd0: load_val = uns_q ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
         2'd1: load_val = uns_q ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
         2'd2: load_val = uns_q ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
         default: load_val = raw;
      endcase
   end

   always_comb begin
      state_d        = state_q;
      dreq_valid_d   = dreq_valid_q;
      dreq_addr_d    = dreq_addr_q;
      dreq_size_d    = dreq_size_q;
      dreq_strobe_d  = dreq_strobe_q;
      dreq_data_d    = dreq_data_q;
      pc_d           = pc_q;
      uns_d          = uns_q;
      load_d         = load_q;
      out_valid_d    = out_valid_q;
      out_pc_d       = out_pc_q;
      out_result_d   = out_result_q;
      out_misalign_d = out_misalign_q;
      finish         = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               pc_d          = in_pc;
               dreq_addr_d   = in_alu;
               dreq_size_d   = in_size;
               dreq_strobe_d = in_mem_write ? strobe_in : 8'h00;
               dreq_data_d   = data_in;
               uns_d         = in_unsigned;
               load_d        = in_mem_read;
               if (is_mem_in && !suppress_in) begin
                  state_d      = REQ;
                  dreq_valid_d = 1'b1;
                  out_valid_d  = 1'b0;
               end else begin
                  out_valid_d    = 1'b1;
                  out_pc_d       = in_pc;
                  out_result_d   = in_alu;
                  out_misalign_d = suppress_in;
               end
            end else if (out_ready) begin
               out_valid_d = 1'b0;
            end
         end
         REQ: begin
            // data_ok is only meaningful once the request has been accepted.
            if (dbus.dresp_addr_ok) begin
               dreq_valid_d = 1'b0;
               if (dbus.dresp_data_ok) finish = 1'b1;
               else                    state_d = WAIT;
            end
         end
         WAIT: begin
            if (dbus.dresp_data_ok) finish = 1'b1;
         end
         DONE: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      if (finish) begin
         state_d        = DONE;
         out_valid_d    = 1'b1;
         out_pc_d       = pc_q;
         out_result_d   = load_q ? load_val : dreq_addr_q;
         out_misalign_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= IDLE;
         dreq_valid_q   <= 1'b0;
         dreq_addr_q    <= '0;
         dreq_size_q    <= '0;
         dreq_strobe_q  <= '0;
         dreq_data_q    <= '0;
         pc_q           <= '0;
         uns_q          <= 1'b0;
         load_q         <= 1'b0;
         out_valid_q    <= 1'b0;
         out_pc_q       <= '0;
         out_result_q   <= '0;
         out_misalign_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         dreq_valid_q   <= dreq_valid_d;
         dreq_addr_q    <= dreq_addr_d;
         dreq_size_q    <= dreq_size_d;
         dreq_strobe_q  <= dreq_strobe_d;
         dreq_data_q    <= dreq_data_d;
         pc_q           <= pc_d;
         uns_q          <= uns_d;
         load_q         <= load_d;
         out_valid_q    <= out_valid_d;
         out_pc_q       <= out_pc_d;
         out_result_q   <= out_result_d;
         out_misalign_q <= out_misalign_d;
      end
   end

   assign dbus.dreq_valid  = dreq_valid_q;
   assign dbus.dreq_addr   = dreq_addr_q;
   assign dbus.dreq_size   = dreq_size_q;
   assign dbus.dreq_strobe = dreq_strobe_q;
   assign dbus.dreq_data   = dreq_data_q;
   assign out_valid        = out_valid_q;
   assign out_pc           = out_pc_q;
   assign out_result       = out_result_q;
   assign out_misalign     = out_misalign_q;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: expected results queued at issue, compared at the
// writeback handshake; a scripted bus responder drives addr_ok/data_ok timing.
module tb_memory_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [63:0] in_pc, in_alu, in_rs2;
  logic        in_mem_read, in_mem_write, in_unsigned;
  logic [1:0]  in_size;
  logic        out_valid, out_ready, out_misalign;
  logic [63:0] out_pc, out_result;

  memory_stage_if dbus();

  memory_stage #(.CHECK_ALIGN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_alu(in_alu),
    .in_rs2(in_rs2), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_size(in_size), .in_unsigned(in_unsigned), .dbus(dbus),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_result(out_result), .out_misalign(out_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] res;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic mis_f(input logic [63:0] a, input logic [1:0] sz);
    logic [63:0] m;
    m = (64'd1 << sz) - 64'd1;
    return (a & m) != 64'd0;
  endfunction

  function automatic logic [63:0] ld_model(input logic [63:0] d, input int off,
                                          input logic [1:0] sz, input logic u);
    logic [63:0] r;
    int nb;
    r  = '0;
    nb = 1 << sz;
    for (int i = 0; i < 8; i++)
      if (i < nb && off + i < 8) r[i*8 +: 8] = d[(off+i)*8 +: 8];
    if (!u && r[nb*8-1])
      for (int i = 0; i < 64; i++) if (i >= nb*8) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [7:0] strb_model(input int off, input logic [1:0] sz);
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) if (i < (1 << sz) && off + i < 8) s[off+i] = 1'b1;
    return s;
  endfunction

  // Writeback-side monitor: every handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexp_out", 64'd1, 64'd0);
      else begin
        mon_e = sb.pop_front();
        chk("out_pc", out_pc, mon_e.pc);
        chk("out_res", out_result, mon_e.res);
        chk("out_mis", {63'd0, out_misalign}, {63'd0, mon_e.mis});
      end
    end
  end

  task automatic issue(input logic [63:0] pc, input logic [63:0] alu, input logic [63:0] rs2,
                       input logic rd, input logic wr, input logic [1:0] sz, input logic u,
                       input logic push, input logic [63:0] rdata);
    exp_t e;
    int   t;
    in_pc = pc; in_alu = alu; in_rs2 = rs2; in_mem_read = rd; in_mem_write = wr;
    in_size = sz; in_unsigned = u; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 20) begin step(); t++; end
    if (t >= 20) chk("rdy_timeout", 64'd0, 64'd1);
    e.pc  = pc;
    e.mis = (rd || wr) && mis_f(alu, sz);
    e.res = (rd && !e.mis) ? ld_model(rdata, int'(alu[2:0]), sz, u) : alu;
    if (push) sb.push_back(e);
    step();
    in_valid = 1'b0;
  endtask

  // Called just after accept: holds the request ack_dly cycles, then completes.
  task automatic bus(input int ack_dly, input int data_dly, input logic [63:0] rdata,
                     input logic [63:0] ea, input logic [7:0] es, input logic [63:0] ed);
    for (int i = 0; i <= ack_dly; i++) begin
      chk("req_vld", {63'd0, dbus.dreq_valid}, 64'd1);
      chk("req_addr", dbus.dreq_addr, ea);
      chk("req_strb", {56'd0, dbus.dreq_strobe}, {56'd0, es});
      if (es != 8'h00) chk("req_data", dbus.dreq_data, ed);
      if (i < ack_dly) step();
    end
    dbus.dresp_addr_ok = 1'b1;
    dbus.dresp_data    = rdata;
    if (data_dly == 0) dbus.dresp_data_ok = 1'b1;
    step();
    dbus.dresp_addr_ok = 1'b0;
    dbus.dresp_data_ok = 1'b0;
    if (data_dly > 0) begin
      chk("req_drop", {63'd0, dbus.dreq_valid}, 64'd0);
      repeat (data_dly - 1) step();
      dbus.dresp_data_ok = 1'b1;
      step();
      dbus.dresp_data_ok = 1'b0;
    end
    chk("done_vld", {63'd0, out_valid}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a, d, r;
    logic [1:0]  sz;
    logic        rd, u;
    int          o, ad, dd;

    reset = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
    in_pc = '0; in_alu = '0; in_rs2 = '0; in_mem_read = 1'b0; in_mem_write = 1'b0;
    in_size = '0; in_unsigned = 1'b0;
    dbus.dresp_addr_ok = 1'b0; dbus.dresp_data_ok = 1'b0; dbus.dresp_data = '0;
    repeat (3) step();
    chk("rst_ovld", {63'd0, out_valid}, 64'd0);
    chk("rst_dvld", {63'd0, dbus.dreq_valid}, 64'd0);
    chk("rst_pc", out_pc, 64'd0);
    chk("rst_res", out_result, 64'd0);
    chk("rst_mis", {63'd0, out_misalign}, 64'd0);
    chk("rst_rdy", {63'd0, in_ready}, 64'd1);
    reset = 1'b1;
    step();

    // Non-memory pass-through
    issue(64'h8000_0000, 64'h1234, 64'd0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 64'd0);
    chk("nm_vld", {63'd0, out_valid}, 64'd1);
    chk("nm_res", out_result, 64'h1234);
    chk("nm_nodreq", {63'd0, dbus.dreq_valid}, 64'd0);
    step();

    // Signed and unsigned byte load at 0x1003
    issue(64'h10, 64'h1003, 64'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 64'h0000_0000_8000_0000);
    bus(0, 1, 64'h0000_0000_8000_0000, 64'h1003, 8'h00, 64'd0);
    chk("lb_res", out_result, 64'hFFFF_FFFF_FFFF_FF80);
    step();
    issue(64'h14, 64'h1003, 64'd0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 64'h0000_0000_8000_0000);
    bus(0, 1, 64'h0000_0000_8000_0000, 64'h1003, 8'h00, 64'd0);
    chk("lbu_res", out_result, 64'h80);
    step();

    // Halfword store, addr_ok delayed 3 cycles
    issue(64'h18, 64'h2006, 64'hABCD, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 64'hDEAD);
    bus(3, 1, 64'hDEAD, 64'h2006, 8'hC0, 64'hABCD_0000_0000_0000);
    step();

    // Misaligned word load is suppressed
    issue(64'h1C, 64'h3002, 64'd0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 64'd0);
    chk("mis_nodreq", {63'd0, dbus.dreq_valid}, 64'd0);
    chk("mis_vld", {63'd0, out_valid}, 64'd1);
    chk("mis_flag", {63'd0, out_misalign}, 64'd1);
    step();

    // Dword load, same-cycle acks, writeback stalled 2 cycles
    issue(64'h20, 64'h4000, 64'd0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 64'h1122_3344_5566_7788);
    out_ready = 1'b0;
    bus(0, 0, 64'h1122_3344_5566_7788, 64'h4000, 8'h00, 64'd0);
    for (int i = 0; i < 2; i++) begin
      chk("stall_vld", {63'd0, out_valid}, 64'd1);
      chk("stall_res", out_result, 64'h1122_3344_5566_7788);
      chk("stall_rdy", {63'd0, in_ready}, 64'd0);
      step();
    end
    out_ready = 1'b1;
    step();

    // Reset while waiting for data_ok, then a stray data_ok
    issue(64'h24, 64'h5000, 64'd0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 64'd0);
    dbus.dresp_addr_ok = 1'b1;
    step();
    dbus.dresp_addr_ok = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("wrst_dvld", {63'd0, dbus.dreq_valid}, 64'd0);
    chk("wrst_ovld", {63'd0, out_valid}, 64'd0);
    chk("wrst_rdy", {63'd0, in_ready}, 64'd1);
    dbus.dresp_data_ok = 1'b1;
    dbus.dresp_data = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    dbus.dresp_data_ok = 1'b0;
    repeat (2) step();
    chk("stray_ovld", {63'd0, out_valid}, 64'd0);

    // Random aligned loads and stores
    for (int k = 0; k < 10; k++) begin
      sz = 2'($urandom_range(0, 3));
      o  = $urandom_range(0, 7);
      o  = o - (o % (1 << sz));
      a  = 64'h6000 + 64'(k * 8) + 64'(o);
      d  = {$urandom, $urandom};
      r  = {$urandom, $urandom};
      rd = 1'($urandom_range(0, 1));
      u  = 1'($urandom_range(0, 1));
      ad = $urandom_range(0, 2);
      dd = $urandom_range(0, 2);
      issue(64'h100 + 64'(k * 4), a, d, rd, !rd, sz, u, 1'b1, r);
      bus(ad, dd, r, a, rd ? 8'h00 : strb_model(o, sz), d << (8 * o));
      step();
    end

    repeat (3) step();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
